ble_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single BLE UART transmit byte stream between two requesters: the feature stream (extracted voice features serialized to bytes) and the status/response stream (classification results and command acknowledgements). It sits between the biometrics feature path, the status generator and the UART transmitter, in front of `ble_uart_tx_out`. The block grants one requester at a time, never interleaves bytes of two packets, honours BLE CTS flow control and force-terminates runaway packets.

---
 rtl/ble_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_ble_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_tx_arbiter.sv
// ble_tx_arbiter: packet-atomic round-robin arbiter sharing the BLE UART
// transmit byte stream between the feature stream (requester 0) and the
// status/response stream (requester 1). Honours BLE CTS (active-low) and
// force-releases packets longer than MAX_PKT_LEN data beats.
// Optional feature: define BLE_TX_HEADER_EN to prefix every granted packet
// with a one-byte header 8'hA0 | requester id.
module ble_tx_arbiter #(
    parameter int MAX_PKT_LEN = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] feat_data_in,
    input  logic       feat_valid_in,
    input  logic       feat_last_in,
    output logic       feat_ready_out,
    input  logic [7:0] stat_data_in,
    input  logic       stat_valid_in,
    input  logic       stat_last_in,
    output logic       stat_ready_out,
    output logic [7:0] tx_data_out,
    output logic       tx_valid_out,
    input  logic       tx_ready_in,
    input  logic       ble_cts_in,
    output logic [1:0] grant_out,
    output logic       overflow_out
);

    localparam int               CNT_W    = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_HDR  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       grant;
    logic             last_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             overflow;

    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             beat;
    logic             any_valid;
    logic             next_id;

    // Route the granted requester's byte, valid and last flag
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        if (grant[0]) begin
            sel_valid = feat_valid_in;
            sel_data  = feat_data_in;
            sel_last  = feat_last_in;
        end else if (grant[1]) begin
            sel_valid = stat_valid_in;
            sel_data  = stat_data_in;
            sel_last  = stat_last_in;
        end
    end

    // Drive the UART side and the requester readies for the current phase
    always_comb begin
        tx_valid_out   = 1'b0;
        tx_data_out    = 8'h00;
        feat_ready_out = 1'b0;
        stat_ready_out = 1'b0;
        if (state == S_DATA) begin
            tx_valid_out   = sel_valid & ~ble_cts_in;
            tx_data_out    = sel_data;
            feat_ready_out = grant[0] & tx_ready_in & ~ble_cts_in;
            stat_ready_out = grant[1] & tx_ready_in & ~ble_cts_in;
        end
`ifdef BLE_TX_HEADER_EN
        else if (state == S_HDR) begin
            // Header byte carries the owner id; requesters are held off
            tx_valid_out = ~ble_cts_in;
            tx_data_out  = 8'hA0 | {7'h00, grant[1]};
        end
`endif
    end

    assign beat      = tx_valid_out & tx_ready_in;
    assign any_valid = feat_valid_in | stat_valid_in;
    // On a tie the requester that did not own the last packet wins
    assign next_id   = (feat_valid_in & stat_valid_in) ? ~last_owner : stat_valid_in;

    assign grant_out    = grant;
    assign overflow_out = overflow;

    // Arbitration FSM: grant, packet beat counting and forced release
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= S_IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant    <= next_id ? 2'b10 : 2'b01;
                        beat_cnt <= '0;
`ifdef BLE_TX_HEADER_EN
                        state    <= S_HDR;
`else
                        state    <= S_DATA;
`endif
                    end
                end
                S_HDR: begin
                    if (beat) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        if (sel_last || (beat_cnt == LAST_IDX)) begin
                            // End of packet, either natural or forced
                            state      <= S_IDLE;
                            grant      <= 2'b00;
                            last_owner <= grant[1];
                            overflow   <= ~sel_last;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_tx_arbiter.sv
// Testbench for ble_tx_arbiter (MAX_PKT_LEN = 8). Directed vector table,
// hand-written reset sequence and a randomized run checked against a
// packet-level model of the arbitration rules.
module tb_ble_tx_arbiter;

    localparam int MAX = 8;
`ifdef BLE_TX_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] feat_data_in;
    logic       feat_valid_in;
    logic       feat_last_in;
    logic       feat_ready_out;
    logic [7:0] stat_data_in;
    logic       stat_valid_in;
    logic       stat_last_in;
    logic       stat_ready_out;
    logic [7:0] tx_data_out;
    logic       tx_valid_out;
    logic       tx_ready_in;
    logic       ble_cts_in;
    logic [1:0] grant_out;
    logic       overflow_out;

    int n_cmp  = 0;
    int n_fail = 0;

    ble_tx_arbiter #(.MAX_PKT_LEN(MAX)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .feat_data_in   (feat_data_in),
        .feat_valid_in  (feat_valid_in),
        .feat_last_in   (feat_last_in),
        .feat_ready_out (feat_ready_out),
        .stat_data_in   (stat_data_in),
        .stat_valid_in  (stat_valid_in),
        .stat_last_in   (stat_last_in),
        .stat_ready_out (stat_ready_out),
        .tx_data_out    (tx_data_out),
        .tx_valid_out   (tx_valid_out),
        .tx_ready_in    (tx_ready_in),
        .ble_cts_in     (ble_cts_in),
        .grant_out      (grant_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       fv;
        logic [7:0] fd;
        logic       fl;
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       tr;
        logic       cts;
        logic       etv;
        logic [7:0] etd;
        logic [1:0] eg;
        logic       efr;
        logic       esr;
        logic       eov;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [7:0] fd, input logic fl,
                         input logic sv, input logic [7:0] sd, input logic sl,
                         input logic tr, input logic cts);
        feat_valid_in = fv; feat_data_in = fd; feat_last_in = fl;
        stat_valid_in = sv; stat_data_in = sd; stat_last_in = sl;
        tx_ready_in   = tr; ble_cts_in   = cts;
    endtask

    task automatic addv(input logic fv, input logic [7:0] fd, input logic fl,
                        input logic sv, input logic [7:0] sd, input logic sl,
                        input logic tr, input logic cts,
                        input logic etv, input logic [7:0] etd, input logic [1:0] eg,
                        input logic efr, input logic esr, input logic eov);
        vec_t v;
        v.fv = fv; v.fd = fd; v.fl = fl; v.sv = sv; v.sd = sd; v.sl = sl;
        v.tr = tr; v.cts = cts; v.etv = etv; v.etd = etd; v.eg = eg;
        v.efr = efr; v.esr = esr; v.eov = eov;
        vq.push_back(v);
    endtask

    // Header row inserted after the IDLE cycle of each packet when enabled
    task automatic hdr(input logic fv, input logic [7:0] fd, input logic fl,
                       input logic sv, input logic [7:0] sd, input logic sl,
                       input logic id, input logic eov);
        if (HDR_EN)
            addv(fv, fd, fl, sv, sd, sl, 1, 0, 1, 8'hA0 | {7'h00, id},
                 id ? 2'b10 : 2'b01, 0, 0, eov);
    endtask

    task automatic build_table();
        logic [7:0] d;
        // Feature-only 4-byte packet
        addv(1, 8'h01, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        hdr (1, 8'h01, 0, 0, 8'h00, 0, 0, 0);
        addv(1, 8'h01, 0, 0, 8'h00, 0, 1, 0, 1, 8'h01, 2'b01, 1, 0, 0);
        addv(1, 8'h02, 0, 0, 8'h00, 0, 1, 0, 1, 8'h02, 2'b01, 1, 0, 0);
        addv(1, 8'h03, 0, 0, 8'h00, 0, 1, 0, 1, 8'h03, 2'b01, 1, 0, 0);
        addv(1, 8'h04, 1, 0, 8'h00, 0, 1, 0, 1, 8'h04, 2'b01, 1, 0, 0);
        addv(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        // Status 3-byte packet with CTS high for 5 cycles after byte 1
        addv(0, 8'h00, 0, 1, 8'hAA, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        hdr (0, 8'h00, 0, 1, 8'hAA, 0, 1, 0);
        addv(0, 8'h00, 0, 1, 8'hAA, 0, 1, 0, 1, 8'hAA, 2'b10, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            addv(0, 8'h00, 0, 1, 8'hBB, 0, 1, 1, 0, 8'hBB, 2'b10, 0, 0, 0);
        addv(0, 8'h00, 0, 1, 8'hBB, 0, 1, 0, 1, 8'hBB, 2'b10, 0, 1, 0);
        addv(0, 8'h00, 0, 1, 8'hCC, 1, 1, 0, 1, 8'hCC, 2'b10, 0, 1, 0);
        addv(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        // Tie after a status packet: feature wins, status follows after one gap cycle
        addv(1, 8'h11, 0, 1, 8'h21, 1, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        hdr (1, 8'h11, 0, 1, 8'h21, 1, 0, 0);
        addv(1, 8'h11, 0, 1, 8'h21, 1, 1, 0, 1, 8'h11, 2'b01, 1, 0, 0);
        addv(1, 8'h12, 1, 1, 8'h21, 1, 1, 0, 1, 8'h12, 2'b01, 1, 0, 0);
        addv(0, 8'h00, 0, 1, 8'h21, 1, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        hdr (0, 8'h00, 0, 1, 8'h21, 1, 1, 0);
        addv(0, 8'h00, 0, 1, 8'h21, 1, 1, 0, 1, 8'h21, 2'b10, 0, 1, 0);
        addv(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        // Single-beat packet held by tx_ready low
        addv(0, 8'h00, 0, 1, 8'h5A, 1, 0, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        hdr (0, 8'h00, 0, 1, 8'h5A, 1, 1, 0);
        addv(0, 8'h00, 0, 1, 8'h5A, 1, 0, 0, 1, 8'h5A, 2'b10, 0, 0, 0);
        addv(0, 8'h00, 0, 1, 8'h5A, 1, 1, 0, 1, 8'h5A, 2'b10, 0, 1, 0);
        addv(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        // Runaway 10-byte feature packet: forced release after beat 8
        addv(1, 8'h31, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
        hdr (1, 8'h31, 0, 0, 8'h00, 0, 0, 0);
        for (int b = 1; b <= 8; b++) begin
            d = 8'h30 + 8'(b);
            addv(1, d, 0, 0, 8'h00, 0, 1, 0, 1, d, 2'b01, 1, 0, 0);
        end
        addv(1, 8'h39, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 1);
        hdr (1, 8'h39, 0, 0, 8'h00, 0, 0, 0);
        addv(1, 8'h39, 0, 0, 8'h00, 0, 1, 0, 1, 8'h39, 2'b01, 1, 0, 0);
        addv(1, 8'h3A, 1, 0, 8'h00, 0, 1, 0, 1, 8'h3A, 2'b01, 1, 0, 0);
        addv(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b00, 0, 0, 0);
    endtask

    task automatic apply_table();
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk_in); #1;
            drive(vq[i].fv, vq[i].fd, vq[i].fl, vq[i].sv, vq[i].sd, vq[i].sl,
                  vq[i].tr, vq[i].cts);
            @(negedge clk_in);
            chk($sformatf("vec%0d.tx_valid", i), tx_valid_out,   vq[i].etv);
            chk($sformatf("vec%0d.tx_data",  i), tx_data_out,    vq[i].etd);
            chk($sformatf("vec%0d.grant",    i), grant_out,      vq[i].eg);
            chk($sformatf("vec%0d.feat_rdy", i), feat_ready_out, vq[i].efr);
            chk($sformatf("vec%0d.stat_rdy", i), stat_ready_out, vq[i].esr);
            chk($sformatf("vec%0d.overflow", i), overflow_out,   vq[i].eov);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".tx_valid"}, tx_valid_out,   0);
        chk({tag, ".tx_data"},  tx_data_out,    0);
        chk({tag, ".grant"},    grant_out,      0);
        chk({tag, ".feat_rdy"}, feat_ready_out, 0);
        chk({tag, ".stat_rdy"}, stat_ready_out, 0);
        chk({tag, ".overflow"}, overflow_out,   0);
    endtask

    // Randomized run: AXI-style sources with a packet-level arbitration model
    task automatic random_run();
        logic [7:0] fq_d[$], sq_d[$];
        logic       fq_l[$], sq_l[$];
        int         fi, si, len, cyc, seg_cnt;
        logic       f_adv, s_adv, fb, sb, txb, lst, term, exp_ov, ov_next, lo;
        logic [1:0] m_grant;
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                fq_d.push_back(8'($urandom)); fq_l.push_back(b == len - 1);
            end
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                sq_d.push_back(8'($urandom)); sq_l.push_back(b == len - 1);
            end
        end
        fi = 0; si = 0; cyc = 0; seg_cnt = 0;
        f_adv = 0; s_adv = 0; exp_ov = 0; lo = 1; m_grant = 2'b00;
        while (cyc < 5000 && !(fi == fq_d.size() && si == sq_d.size())) begin
            @(posedge clk_in); #1;
            cyc++;
            if (f_adv) begin fi++; feat_valid_in = 0; f_adv = 0; end
            if (s_adv) begin si++; stat_valid_in = 0; s_adv = 0; end
            if (!feat_valid_in && fi < fq_d.size() && $urandom_range(0, 3) != 0)
                feat_valid_in = 1;
            if (!stat_valid_in && si < sq_d.size() && $urandom_range(0, 3) != 0)
                stat_valid_in = 1;
            if (feat_valid_in) begin feat_data_in = fq_d[fi]; feat_last_in = fq_l[fi]; end
            if (stat_valid_in) begin stat_data_in = sq_d[si]; stat_last_in = sq_l[si]; end
            tx_ready_in = ($urandom_range(0, 3) != 0);
            ble_cts_in  = ($urandom_range(0, 9) == 0);
            @(negedge clk_in);
            fb  = feat_valid_in & feat_ready_out;
            sb  = stat_valid_in & stat_ready_out;
            txb = tx_valid_out & tx_ready_in;
            chk("rnd.grant", grant_out, m_grant);
            chk("rnd.overflow", overflow_out, exp_ov);
            if (!m_grant[0]) chk("rnd.feat_rdy_not_granted", feat_ready_out, 0);
            if (!m_grant[1]) chk("rnd.stat_rdy_not_granted", stat_ready_out, 0);
            term = 0; ov_next = 0;
            if (fb || sb) begin
                chk("rnd.src_beat_reaches_tx", txb, 1);
                chk("rnd.tx_data", tx_data_out, fb ? fq_d[fi] : sq_d[si]);
                seg_cnt++;
                lst  = fb ? feat_last_in : stat_last_in;
                term = lst || (seg_cnt == MAX);
                ov_next = (seg_cnt == MAX) && !lst;
                if (term) begin lo = sb; seg_cnt = 0; end
                f_adv = fb; s_adv = sb;
            end else if (txb) begin
                chk("rnd.header_byte", tx_data_out,
                    HDR_EN ? (32'hA0 | 32'(m_grant[1])) : 32'h100);
            end
            if (m_grant == 2'b00) begin
                if (feat_valid_in && stat_valid_in) m_grant = lo ? 2'b01 : 2'b10;
                else if (feat_valid_in)             m_grant = 2'b01;
                else if (stat_valid_in)             m_grant = 2'b10;
            end else if (term) begin
                m_grant = 2'b00;
            end
            exp_ov = ov_next;
        end
        chk("rnd.all_bytes_sent", (fi == fq_d.size() && si == sq_d.size()), 1);
    endtask

    initial begin
        rst_in = 0;
        drive(1, 8'h77, 0, 1, 8'h88, 0, 1, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        chk_idle_outputs("reset");
        @(posedge clk_in); #1;
        rst_in = 1;
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);

        build_table();
        apply_table();

        // Reset in the middle of a feature packet at beat 2
        @(posedge clk_in); #1;
        drive(1, 8'h41, 0, 0, 8'h00, 0, 1, 0);
        @(posedge clk_in); #1;
        if (HDR_EN) begin @(posedge clk_in); #1; end
        @(posedge clk_in); #1;
        feat_data_in = 8'h42;
        @(negedge clk_in);
        chk("midrst.pre_grant", grant_out, 2'b01);
        chk("midrst.pre_data", tx_data_out, 8'h42);
        #2 rst_in = 0;
        #1 chk_idle_outputs("midrst");
        @(posedge clk_in); #1;
        rst_in = 1;
        drive(1, 8'h51, 0, 1, 8'h61, 0, 1, 0);
        @(negedge clk_in);
        chk("postrst.idle_grant", grant_out, 2'b00);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("postrst.tie_grant", grant_out, 2'b01);
        chk("postrst.tie_data", tx_data_out, HDR_EN ? 8'hA0 : 8'h51);

        // Clean restart for the randomized run
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        #2 rst_in = 0;
        @(posedge clk_in); #1;
        rst_in = 1;
        random_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
